// File: rtl/risc_controller_fsm_if.sv
// ---------------------------------------------------------------------------
// risc_controller_fsm_if
// Bundles the instruction-side inputs and the datapath control outputs of the
// RISC controller.
//   s        : start request (sampled in WAIT)
//   opcode   : instruction bits [15:13] (sampled in DECODE)
//   op       : instruction bits [12:11] (sampled in DECODE)
//   w        : controller idle in WAIT, ready for s
//   nsel     : one-hot register select (001=Rn, 010=Rd, 100=Rm)
//   vsel     : write-back select (00=C, 01=PC, 10=sximm8, 11=mdata)
//   write, loada, loadb, asel, bsel, loadc, loads : datapath strobes
//   state    : current controller state code (debug)
// Modports: master drives the instruction side, slave is the controller.
// ---------------------------------------------------------------------------
interface risc_controller_fsm_if;
   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       w;
   logic [2:0] nsel;
   logic [1:0] vsel;
   logic       write;
   logic       loada;
   logic       loadb;
   logic       asel;
   logic       bsel;
   logic       loadc;
   logic       loads;
   logic [2:0] state;

   modport master (
      output s, opcode, op,
      input  w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, state
   );

   modport slave (
      input  s, opcode, op,
      output w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, state
   );
endinterface

// File: rtl/risc_controller_fsm.sv
// ---------------------------------------------------------------------------
// risc_controller_fsm
// Moore controller sequencing a simple RISC datapath for MOV-immediate,
// MOV-register, ADD/AND/MVN and CMP instructions.
//   clk   : single clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : risc_controller_fsm_if.slave (instruction inputs, control outputs)
// All outputs come straight from flops. The output flops are loaded with the
// decoding of the next state, so they always equal the decoding of the
// current state and never depend combinationally on s/opcode/op.
// ---------------------------------------------------------------------------
module risc_controller_fsm (
   input  logic                   clk,
   input  logic                   reset,
   risc_controller_fsm_if.slave   bus
);

   typedef enum logic [2:0] {
      S_WAIT      = 3'b000,
      S_DECODE    = 3'b001,
      S_WRITE_IMM = 3'b010,
      S_GETA      = 3'b011,
      S_GETB      = 3'b100,
      S_ALU       = 3'b101,
      S_MOVSH     = 3'b110,
      S_WRITE_REG = 3'b111
   } state_t;

   typedef enum logic [1:0] {
      CL_MOVIMM = 2'b00,
      CL_MOVREG = 2'b01,
      CL_ALU    = 2'b10,
      CL_CMP    = 2'b11
   } iclass_t;

   typedef struct packed {
      logic       w;
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       asel;
      logic       bsel;
      logic       loadc;
      logic       loads;
   } ctrl_t;

   state_t  state_r;
   state_t  next_state_s;
   iclass_t class_r;
   iclass_t class_next_s;
   ctrl_t   ctrl_r;
   ctrl_t   ctrl_next_s;

   // Control word for a state; anything not named for a state stays 0.
   function automatic ctrl_t ctrl_for(input state_t st, input iclass_t cl);
      ctrl_t c;
      c = ctrl_t'(13'd0);
      case (st)
         S_WAIT: begin
            c.w = 1'b1;
         end
         S_DECODE: begin
            c.w = 1'b0;
         end
         S_WRITE_IMM: begin
            c.nsel  = 3'b001;
            c.vsel  = 2'b10;
            c.write = 1'b1;
         end
         S_GETA: begin
            c.nsel  = 3'b001;
            c.loada = 1'b1;
         end
         S_GETB: begin
            c.nsel  = 3'b100;
            c.loadb = 1'b1;
         end
         S_ALU: begin
            c.loadc = 1'b1;
            c.loads = (cl == CL_CMP) ? 1'b1 : 1'b0;
         end
         S_MOVSH: begin
            c.asel  = 1'b1;
            c.loadc = 1'b1;
         end
         S_WRITE_REG: begin
            c.nsel  = 3'b010;
            c.vsel  = 2'b00;
            c.write = 1'b1;
         end
         default: begin
            c = ctrl_t'(13'd0);
         end
      endcase
      return c;
   endfunction

   // Next-state and instruction-class decode.
   always_comb begin
      next_state_s = S_WAIT;
      class_next_s = class_r;
      case (state_r)
         S_WAIT: begin
            if (bus.s) begin
               next_state_s = S_DECODE;
            end else begin
               next_state_s = S_WAIT;
            end
         end
         S_DECODE: begin
            // Undefined encodings fall back to WAIT and leave the class as is.
            case ({bus.opcode, bus.op})
               5'b110_10: begin
                  next_state_s = S_WRITE_IMM;
                  class_next_s = CL_MOVIMM;
               end
               5'b110_00: begin
                  next_state_s = S_GETB;
                  class_next_s = CL_MOVREG;
               end
               5'b101_01: begin
                  next_state_s = S_GETA;
                  class_next_s = CL_CMP;
               end
               5'b101_00, 5'b101_10, 5'b101_11: begin
                  next_state_s = S_GETA;
                  class_next_s = CL_ALU;
               end
               default: begin
                  next_state_s = S_WAIT;
                  class_next_s = class_r;
               end
            endcase
         end
         S_WRITE_IMM: begin
            next_state_s = S_WAIT;
         end
         S_GETA: begin
            next_state_s = S_GETB;
         end
         S_GETB: begin
            if (class_r == CL_MOVREG) begin
               next_state_s = S_MOVSH;
            end else begin
               next_state_s = S_ALU;
            end
         end
         S_ALU: begin
            if (class_r == CL_CMP) begin
               next_state_s = S_WAIT;
            end else begin
               next_state_s = S_WRITE_REG;
            end
         end
         S_MOVSH: begin
            next_state_s = S_WRITE_REG;
         end
         S_WRITE_REG: begin
            next_state_s = S_WAIT;
         end
         default: begin
            next_state_s = S_WAIT;
         end
      endcase
   end

   // Control word to be presented once the next state is entered.
   always_comb begin
      ctrl_next_s = ctrl_for(next_state_s, class_next_s);
   end

   // State, latched class and registered outputs; reset overrides everything.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= S_WAIT;
         class_r <= CL_MOVIMM;
         ctrl_r  <= ctrl_for(S_WAIT, CL_MOVIMM);
      end else begin
         state_r <= next_state_s;
         class_r <= class_next_s;
         ctrl_r  <= ctrl_next_s;
      end
   end

   assign bus.w     = ctrl_r.w;
   assign bus.nsel  = ctrl_r.nsel;
   assign bus.vsel  = ctrl_r.vsel;
   assign bus.write = ctrl_r.write;
   assign bus.loada = ctrl_r.loada;
   assign bus.loadb = ctrl_r.loadb;
   assign bus.asel  = ctrl_r.asel;
   assign bus.bsel  = ctrl_r.bsel;
   assign bus.loadc = ctrl_r.loadc;
   assign bus.loads = ctrl_r.loads;
   assign bus.state = state_r;

endmodule
